// File: rtl/alu_result_serializer.sv
// alu_result_serializer
//   Sits behind the four ALU execution units (arith/logic/cmp/shift). Notes
//   which unit was enabled, grabs that unit's registered result and flag one
//   cycle later, buffers it in a DEPTH-entry FIFO and streams each entry out
//   LSB byte first over a valid/ready byte link.
//
//   Optional build macro ALU_SER_STATUS_BYTE_EN: appends a status byte
//   {flag, 1'b0, unit_id[1:0], 4'b0101} after the data bytes of each frame.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   *_enable                 per-unit op enables (same as the units see)
//   *_out [WIDTH-1:0]        per-unit registered results
//   *_flag                   per-unit flags
//   tx_data/tx_valid/tx_ready byte stream out
//   busy                     work pending anywhere in the block
//   overflow, multi_err      sticky error flags, cleared by err_clr
module alu_result_serializer #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arith_enable,
  input  logic             logic_enable,
  input  logic             cmp_enable,
  input  logic             shift_enable,
  input  logic [WIDTH-1:0] arith_out,
  input  logic [WIDTH-1:0] logic_out,
  input  logic [WIDTH-1:0] cmp_out,
  input  logic [WIDTH-1:0] shift_out,
  input  logic             arith_flag,
  input  logic             logic_flag,
  input  logic             cmp_flag,
  input  logic             shift_flag,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready,
  output logic             busy,
  output logic             overflow,
  output logic             multi_err,
  input  logic             err_clr
);

  localparam int DB = WIDTH / 8;
`ifdef ALU_SER_STATUS_BYTE_EN
  localparam int NB = DB + 1;
  localparam int EW = WIDTH + 3;  // {flag, unit_id, result}
`else
  localparam int NB = DB;
  localparam int EW = WIDTH;
`endif
  localparam int IW = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {S_IDLE = 1'b0, S_SEND = 1'b1} state_t;

  // ---------------- capture stage ----------------
  logic       pend_valid_q, pend_valid_d;
  logic [1:0] pend_unit_q, pend_unit_d;
  logic       multi_evt;

  always_comb begin
    pend_valid_d = arith_enable | logic_enable | cmp_enable | shift_enable;
    pend_unit_d  = 2'd3;
    if (arith_enable)      pend_unit_d = 2'd0;
    else if (logic_enable) pend_unit_d = 2'd1;
    else if (cmp_enable)   pend_unit_d = 2'd2;
    multi_evt = (arith_enable & (logic_enable | cmp_enable | shift_enable)) |
                (logic_enable & (cmp_enable | shift_enable)) |
                (cmp_enable & shift_enable);
  end

  // ---------------- result select ----------------
  logic [WIDTH-1:0] res_sel;
  logic             flag_sel;
  logic [EW-1:0]    push_data;

  always_comb begin
    unique case (pend_unit_q)
      2'd0:    begin res_sel = arith_out; flag_sel = arith_flag; end
      2'd1:    begin res_sel = logic_out; flag_sel = logic_flag; end
      2'd2:    begin res_sel = cmp_out;   flag_sel = cmp_flag;   end
      default: begin res_sel = shift_out; flag_sel = shift_flag; end
    endcase
`ifdef ALU_SER_STATUS_BYTE_EN
    push_data = {flag_sel, pend_unit_q, res_sel};
`else
    push_data = res_sel;
`endif
  end

`ifndef ALU_SER_STATUS_BYTE_EN
  // Flags are not stored without the status byte.
  logic unused_flag;
  assign unused_flag = flag_sel;
`endif

  // ---------------- FIFO ----------------
  logic [DEPTH-1:0][EW-1:0] mem_q, mem_d;
  logic [AW-1:0]            wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     empty, full, pop, push_ok, ovf_evt;
  logic [EW-1:0]            fifo_head;

  always_comb begin
    empty     = (cnt_q == '0);
    full      = (cnt_q == CW'(DEPTH));
    // A full FIFO still takes the push when the serializer pops on the same edge.
    push_ok   = pend_valid_q & (~full | pop);
    ovf_evt   = pend_valid_q & full & ~pop;
    fifo_head = mem_q[rptr_q];
    mem_d     = mem_q;
    if (push_ok) mem_d[wptr_q] = push_data;
    wptr_d = push_ok ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop     ? rptr_q + 1'b1 : rptr_q;
    unique case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // ---------------- sticky errors ----------------
  logic overflow_q, overflow_d, multi_err_q, multi_err_d;

  always_comb begin
    // A new error in the clear cycle wins.
    overflow_d  = (overflow_q  & ~err_clr) | ovf_evt;
    multi_err_d = (multi_err_q & ~err_clr) | multi_evt;
  end

  // ---------------- serializer FSM ----------------
  state_t        state_q, state_d;
  logic [EW-1:0] sh_q, sh_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          hs, last;
  logic [NB-1:0][7:0] frame_bytes;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    hs      = tx_valid & tx_ready;
    last    = (idx_q == IW'(NB - 1));
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (!empty) state_d = S_SEND;
      default: if (hs && last && empty) state_d = S_IDLE;
    endcase
  end

  // outputs
  always_comb begin
    for (int i = 0; i < DB; i++) frame_bytes[i] = sh_q[8*i +: 8];
`ifdef ALU_SER_STATUS_BYTE_EN
    frame_bytes[DB] = {sh_q[WIDTH+2], 1'b0, sh_q[WIDTH+1:WIDTH], 4'b0101};
`endif
    tx_valid = (state_q == S_SEND);
    tx_data  = '0;
    if (tx_valid) begin
      for (int i = 0; i < NB; i++)
        if (idx_q == IW'(i)) tx_data = frame_bytes[i];
    end
    busy      = ~empty | tx_valid | pend_valid_q;
    overflow  = overflow_q;
    multi_err = multi_err_q;
  end

  // Shift register load: from IDLE, or straight after the last byte so
  // back-to-back frames have no bubble.
  always_comb begin
    pop   = ~empty & ((state_q == S_IDLE) | (hs & last));
    sh_d  = sh_q;
    idx_d = idx_q;
    if (pop) begin
      sh_d  = fifo_head;
      idx_d = '0;
    end else if (hs) begin
      idx_d = idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid_q <= 1'b0;
      pend_unit_q  <= '0;
      mem_q        <= '0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      overflow_q   <= 1'b0;
      multi_err_q  <= 1'b0;
      sh_q         <= '0;
      idx_q        <= '0;
    end else begin
      pend_valid_q <= pend_valid_d;
      pend_unit_q  <= pend_unit_d;
      mem_q        <= mem_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
      multi_err_q  <= multi_err_d;
      sh_q         <= sh_d;
      idx_q        <= idx_d;
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Testbench for alu_result_serializer: directed scenarios followed by random
// traffic, all checked each cycle against a queue-based reference model.
module tb_alu_result_serializer;
  localparam int WIDTH = 16;
  localparam int DEPTH = 4;
  localparam int DB = WIDTH / 8;
`ifdef ALU_SER_STATUS_BYTE_EN
  localparam int NB = DB + 1;
`else
  localparam int NB = DB;
`endif

  logic clk = 1'b0;
  logic rst;
  logic arith_enable, logic_enable, cmp_enable, shift_enable;
  logic [WIDTH-1:0] arith_out, logic_out, cmp_out, shift_out;
  logic arith_flag, logic_flag, cmp_flag, shift_flag;
  logic [7:0] tx_data;
  logic tx_valid, tx_ready, busy, overflow, multi_err, err_clr;

  alu_result_serializer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .arith_enable(arith_enable), .logic_enable(logic_enable),
    .cmp_enable(cmp_enable), .shift_enable(shift_enable),
    .arith_out(arith_out), .logic_out(logic_out),
    .cmp_out(cmp_out), .shift_out(shift_out),
    .arith_flag(arith_flag), .logic_flag(logic_flag),
    .cmp_flag(cmp_flag), .shift_flag(shift_flag),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .overflow(overflow), .multi_err(multi_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             flag;
    logic [1:0]       unit;
    logic [WIDTH-1:0] res;
  } ent_t;

  // reference model state
  ent_t       m_fifo[$];
  logic [7:0] m_frame[$];
  logic       m_pend_valid;
  logic [1:0] m_pend_unit;
  logic       m_ovf, m_multi;

  logic [7:0] rx[$];
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One reference-model clock edge using the inputs currently driven.
  task automatic model_edge();
    bit   hs, pop, ovf_evt;
    int   nen;
    ent_t e;
    if (rst) begin
      m_fifo.delete(); m_frame.delete();
      m_pend_valid = 0; m_pend_unit = 0; m_ovf = 0; m_multi = 0;
      return;
    end
    hs  = (m_frame.size() > 0) && tx_ready;
    pop = 0;
    if (m_frame.size() == 0)           pop = (m_fifo.size() > 0);
    else if (hs && m_frame.size() == 1) pop = (m_fifo.size() > 0);
    if (hs) void'(m_frame.pop_front());
    if (pop) begin
      e = m_fifo.pop_front();
      for (int i = 0; i < DB; i++) m_frame.push_back(e.res[8*i +: 8]);
`ifdef ALU_SER_STATUS_BYTE_EN
      m_frame.push_back({e.flag, 1'b0, e.unit, 4'b0101});
`endif
    end
    ovf_evt = 0;
    if (m_pend_valid) begin
      e.unit = m_pend_unit;
      case (m_pend_unit)
        2'd0: begin e.res = arith_out; e.flag = arith_flag; end
        2'd1: begin e.res = logic_out; e.flag = logic_flag; end
        2'd2: begin e.res = cmp_out;   e.flag = cmp_flag;   end
        default: begin e.res = shift_out; e.flag = shift_flag; end
      endcase
      if (m_fifo.size() < DEPTH) m_fifo.push_back(e);
      else ovf_evt = 1;
    end
    nen = int'(arith_enable) + int'(logic_enable) + int'(cmp_enable) + int'(shift_enable);
    m_ovf   = (m_ovf && !err_clr) || ovf_evt;
    m_multi = (m_multi && !err_clr) || (nen > 1);
    m_pend_valid = (nen > 0);
    m_pend_unit  = arith_enable ? 2'd0 : logic_enable ? 2'd1 : cmp_enable ? 2'd2 : 2'd3;
  endtask

  task automatic check_outputs();
    chk("tx_valid", tx_valid, m_frame.size() > 0);
    chk("tx_data", tx_data, (m_frame.size() > 0) ? m_frame[0] : 8'h00);
    chk("busy", busy, (m_fifo.size() > 0) || (m_frame.size() > 0) || m_pend_valid);
    chk("overflow", overflow, m_ovf);
    chk("multi_err", multi_err, m_multi);
  endtask

  // Advance one cycle; on return we sit at the negedge of the new cycle.
  task automatic tick();
    if (tx_valid && tx_ready) rx.push_back(tx_data);
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    logic [15:0] b2b [3];
    logic [7:0]  exp_b;
    rst = 1; err_clr = 0; tx_ready = 0;
    arith_enable = 0; logic_enable = 0; cmp_enable = 0; shift_enable = 0;
    arith_out = 0; logic_out = 0; cmp_out = 0; shift_out = 0;
    arith_flag = 0; logic_flag = 0; cmp_flag = 0; shift_flag = 0;
    m_pend_valid = 0; m_pend_unit = 0; m_ovf = 0; m_multi = 0;
    @(negedge clk);
    tick(); tick();
    chk("reset_valid", tx_valid, 1'b0);
    chk("reset_busy", busy, 1'b0);
    rst = 0;
    tick();

    // single compare
    cmp_enable = 1; tick();
    cmp_enable = 0; cmp_out = 16'h0001; cmp_flag = 1; tx_ready = 1; tick();
    tick();
    chk("cmp_b0_valid", tx_valid, 1'b1);
    chk("cmp_b0", tx_data, 8'h01);
    tick();
    chk("cmp_b1", tx_data, 8'h00);
`ifdef ALU_SER_STATUS_BYTE_EN
    tick();
    chk("cmp_status", tx_data, 8'hA5);
`endif
    repeat (3) tick();
    chk("cmp_idle_busy", busy, 1'b0);

    // backpressure
    tx_ready = 0;
    arith_enable = 1; tick();
    arith_enable = 0; arith_out = 16'hBEEF; tick();
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", tx_valid, 1'b1);
      chk("bp_hold_data", tx_data, 8'hEF);
      tick();
    end
    rx.delete();
    tx_ready = 1;
    repeat (NB + 2) tick();
    chk("bp_count", rx.size(), NB);
    chk("bp_b0", rx[0], 8'hEF);
    chk("bp_b1", rx[1], 8'hBE);

    // overflow: six logic ops while the link is stalled
    tx_ready = 0;
    for (int k = 0; k <= 6; k++) begin
      logic_enable = (k < 6);
      logic_out = 16'(k);
      tick();
    end
    logic_enable = 0;
    tick(); tick();
    chk("ovf_set", overflow, 1'b1);
    rx.delete();
    tx_ready = 1;
    repeat (5 * NB + 4) tick();
    chk("ovf_frames", rx.size(), 5 * NB);
    for (int f = 0; f < 5; f++) begin
      chk("ovf_lo", rx[f*NB], 8'(f + 1));
      chk("ovf_hi", rx[f*NB+1], 8'h00);
    end
    err_clr = 1; tick();
    err_clr = 0;
    chk("ovf_clr", overflow, 1'b0);

    // back-to-back shift frames: all bytes in consecutive cycles
    b2b[0] = 16'h1234; b2b[1] = 16'h5678; b2b[2] = 16'h9ABC;
    shift_flag = 0;
    rx.delete();
    for (int k = 0; k < 4; k++) begin
      shift_enable = (k < 3);
      shift_out = (k == 0) ? 16'h0000 : b2b[k-1];
      tick();
    end
    shift_enable = 0;
    repeat (3 * NB - 1) tick();
    chk("b2b_count", rx.size(), 3 * NB);
    for (int f = 0; f < 3; f++) begin
      exp_b = b2b[f][7:0];
      chk("b2b_lo", rx[f*NB], exp_b);
      exp_b = b2b[f][15:8];
      chk("b2b_hi", rx[f*NB+1], exp_b);
`ifdef ALU_SER_STATUS_BYTE_EN
      chk("b2b_status", rx[f*NB+2], 8'h35);
`endif
    end
    tick();
    chk("b2b_end_valid", tx_valid, 1'b0);

    // multi-enable: arith wins
    arith_enable = 1; cmp_enable = 1; tick();
    arith_enable = 0; cmp_enable = 0;
    arith_out = 16'h1357; cmp_out = 16'h2468;
    chk("multi_set", multi_err, 1'b1);
    rx.delete();
    repeat (NB + 3) tick();
    chk("multi_b0", rx[0], 8'h57);
    chk("multi_b1", rx[1], 8'h13);
    err_clr = 1; tick();
    err_clr = 0;
    chk("multi_clr", multi_err, 1'b0);

    // reset mid-frame
    arith_enable = 1; tick();
    arith_enable = 0; arith_out = 16'hCAFE; tick();
    tick();
    chk("rst_b0", tx_data, 8'hFE);
    tick();
    chk("rst_b1", tx_data, 8'hCA);
    rst = 1; tick();
    rst = 0;
    chk("rst_valid", tx_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    arith_enable = 1; tick();
    arith_enable = 0; arith_out = 16'h0BAD; tick();
    tick();
    chk("post_rst_b0", tx_data, 8'hAD);
    tick();
    chk("post_rst_b1", tx_data, 8'h0B);
    repeat (4) tick();

    // random traffic
    for (int c = 0; c < 600; c++) begin
      rst          = ($urandom_range(0, 199) == 0);
      arith_enable = ($urandom_range(0, 5) == 0);
      logic_enable = ($urandom_range(0, 5) == 0);
      cmp_enable   = ($urandom_range(0, 5) == 0);
      shift_enable = ($urandom_range(0, 5) == 0);
      arith_out = 16'($urandom); logic_out = 16'($urandom);
      cmp_out   = 16'($urandom); shift_out = 16'($urandom);
      arith_flag = 1'($urandom); logic_flag = 1'($urandom);
      cmp_flag   = 1'($urandom); shift_flag = 1'($urandom);
      tx_ready = ($urandom_range(0, 2) != 0);
      err_clr  = ($urandom_range(0, 15) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/alu_result_serializer.md
Name: alu_result_serializer

Overview:
- Downstream stage of the ALU execution units: arithmetic, logic, compare and shift.
- Tracks which unit was enabled, captures that unit's registered result and flag one cycle later, and buffers the result in a small FIFO.
- Streams each buffered result out as bytes, LSB first, over a valid/ready link to the system controller / UART TX path.
- Lets the ALU issue one operation per cycle while the byte link stalls.

Parameters:
- WIDTH, 16, ALU result width; multiple of 8, range 8..64
- DEPTH, 4, FIFO entries; power of 2, >= 2

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- arith_enable  in  1  same enable that drives the arithmetic unit
- logic_enable  in  1  same enable that drives the logic unit
- cmp_enable  in  1  same enable that drives the compare unit
- shift_enable  in  1  same enable that drives the shift unit
- arith_out  in  WIDTH  arithmetic unit registered result
- logic_out  in  WIDTH  logic unit registered result
- cmp_out  in  WIDTH  compare unit registered result
- shift_out  in  WIDTH  shift unit registered result
- arith_flag  in  1  arithmetic unit flag
- logic_flag  in  1  logic unit flag
- cmp_flag  in  1  compare unit flag
- shift_flag  in  1  shift unit flag
- tx_data  out  8  current byte
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  consumer accepts byte
- busy  out  1  FIFO non-empty or frame in progress
- overflow  out  1  sticky: result dropped because FIFO full
- multi_err  out  1  sticky: more than one enable asserted in the same cycle
- err_clr  in  1  clears both sticky flags

Behaviour:
- Reset: synchronous, active-high, on the clk edge. Applies to every register.
  - All outputs are 0 and the FIFO is empty.
  - Reset mid-frame aborts the frame; tx_valid is 0 from the cycle after the reset edge.
- Capture stage:
  - At the edge ending cycle N, register pend_valid = OR of the enables and pend_unit = selected unit id.
  - Unit ids: arith=0, logic=1, cmp=2, shift=3.
  - Priority is arith > logic > cmp > shift.
  - Two or more enables in one cycle set multi_err; the winner is still captured.
- Push:
  - In cycle N+1, the unit outputs hold the results for the cycle-N op.
  - If pend_valid, push {flag, unit_id, result} of pend_unit at the edge ending N+1.
  - The flag is captured as-is; flag=0, e.g. a false compare, is still pushed.
- Throughput: one push per cycle.
- FIFO full:
  - A push is accepted if a pop occurs on the same edge.
  - Otherwise the push is dropped, overflow is set, and FIFO contents are unchanged.
- Sticky flags:
  - err_clr clears both flags.
  - If err_clr and a new error occur in the same cycle, the flag ends set.
- Serializer FSM, states IDLE and SEND:
  - IDLE: when the FIFO is non-empty, pop into the shift register at the edge and go to SEND, byte index 0.
  - SEND: tx_valid=1 and tx_data = result[8*idx+7:8*idx].
  - tx_data is stable while tx_valid && !tx_ready.
  - On handshake (tx_valid && tx_ready), idx increments.
- Last byte (idx = WIDTH/8-1, or the status byte if enabled):
  - On handshake, pop the next entry in the same edge if the FIFO is non-empty; tx_valid stays 1, no bubble.
  - Otherwise go to IDLE; tx_valid is 0 next cycle.
- Latency: an enable in cycle N with tx_ready=1 and an empty FIFO gives the first byte on tx_data with tx_valid in cycle N+3.
- busy = FIFO non-empty OR state == SEND OR pend_valid.

Optional Feature:
- Macro: ALU_SER_STATUS_BYTE_EN.
- Defined:
  - After the data bytes, one extra byte {flag, 1'b0, unit_id[1:0], 4'b0101} is sent, giving WIDTH/8+1 bytes per frame.
  - The 0101 nibble is a frame marker.
- Undefined:
  - Exactly WIDTH/8 bytes per frame.
  - flag and unit_id are not stored, so FIFO width = WIDTH.

Test Plan:
- Single compare:
  - Stimulus: reset, cmp_enable=1 for 1 cycle, next cycle cmp_out=16'h0001 with cmp_flag=1, tx_ready=1.
  - Response: bytes 0x01 then 0x00 from cycle N+3.
  - With the macro: a third byte 0xA5.
- Backpressure:
  - Stimulus: arith result 16'hBEEF, tx_ready=0 for 5 cycles.
  - Response: tx_data holds 0xEF with tx_valid=1 for all 5 cycles, then 0xEF and 0xBE on consecutive handshakes.
- Overflow, DEPTH=4, tx_ready=0:
  - Stimulus: 6 back-to-back logic_enable ops with results 1..6.
  - Response: overflow=1. The first entry goes straight to the serializer, the next 4 are buffered and the 6th is dropped.
  - After releasing tx_ready, 5 frames (1..5) come out in order.
- Back-to-back frames:
  - Stimulus: 3 shift ops in consecutive cycles with results 0x1234, 0x5678, 0x9ABC, tx_ready=1.
  - Response: 6 consecutive bytes 34,12,78,56,BC,9A with no tx_valid gap.
- Multi-enable:
  - Stimulus: arith_enable and cmp_enable in the same cycle.
  - Response: multi_err=1 and the arith result is captured.
  - err_clr pulse clears it next cycle.
- Reset mid-frame:
  - Stimulus: assert rst after the first byte handshake of 0xCAFE.
  - Response: tx_valid=0, busy=0, FIFO empty; the next op serializes normally.
